// File: rtl/pdp11_bus_pkg.sv
// -----------------------------------------------------------------------------
// pdp11_bus_pkg
// Purpose : Shared definitions for the PDP-11 memory bus. This package holds
//           the responder FSM state encoding, the byte-lane constants and the
//           bus-error trap vector that the control unit also uses.
// Contents:
//   state_t        - responder FSM states (IDLE / WAIT / ACK)
//   LANE_LO/HI     - byte-lane numbers (address bit 0 value)
//   BUS_ERR_VECTOR - trap vector taken on a bus error (octal 4)
//   laneEnables()  - per-lane write enables for a word or byte access
// -----------------------------------------------------------------------------
package pdp11_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  localparam logic [15:0] BUS_ERR_VECTOR = 16'o4;

  // A word access writes both lanes. A byte access writes only the lane
  // that address bit 0 selects.
  function automatic logic [1:0] laneEnables(input logic bytew, input logic lane);
    logic [1:0] en;
    en = 2'b11;
    if (bytew) begin
      en = (lane == LANE_HI) ? 2'b10 : 2'b01;
    end
    return en;
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// -----------------------------------------------------------------------------
// mem_byte_array
// Purpose : Word-organised RAM built from two 8-bit banks, one per byte lane.
//           Each lane has its own write enable, so a byte write leaves the
//           other lane untouched. Reads are asynchronous.
//           The contents are deliberately not reset.
// Ports   :
//   i_clk      in   1        write clock (posedge)
//   i_wordAddr in   WORD_AW  word index
//   i_laneWe   in   2        write enable per lane ([0]=low, [1]=high)
//   i_wrData   in   16       write data, high lane in [15:8]
//   o_rdData   out  16       asynchronous read of word i_wordAddr
// -----------------------------------------------------------------------------
module mem_byte_array
  import pdp11_bus_pkg::*;
#(
  parameter int WORD_AW = 12
) (
  input  logic               i_clk,
  input  logic [WORD_AW-1:0] i_wordAddr,
  input  logic [1:0]         i_laneWe,
  input  logic [15:0]        i_wrData,
  output logic [15:0]        o_rdData
);

  localparam int DEPTH = 1 << WORD_AW;

  logic [7:0] r_bankLo [DEPTH];
  logic [7:0] r_bankHi [DEPTH];

  // Each lane commits independently, under its own enable.
  always_ff @(posedge i_clk) begin
    if (i_laneWe[LANE_LO]) begin
      r_bankLo[i_wordAddr] <= i_wrData[7:0];
    end
    if (i_laneWe[LANE_HI]) begin
      r_bankHi[i_wordAddr] <= i_wrData[15:8];
    end
  end

  assign o_rdData = {r_bankHi[i_wordAddr], r_bankLo[i_wordAddr]};

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Purpose : Memory-side bus responder for the PDP-11 datapath. It serves word
//           and byte reads and writes to a byte-addressed, 16-bit-wide RAM.
//           The initiator uses a req/ack handshake. The responder inserts
//           WAIT_STATES wait cycles before each ack.
//           A non-existent-memory access is flagged on o_err together with
//           o_ack, so that control can trap to vector 4. An odd-address word
//           access is flagged the same way when the trap is enabled.
// Build option:
//   ODD_ADDR_TRAP_EN - when defined, a word access with addr[0]=1 is aborted
//                      with o_err. When undefined, addr[0] is ignored for
//                      word accesses.
// Parameters:
//   ADDR_WIDTH  - number of byte-address bits implemented (default 13)
//   WAIT_STATES - extra cycles between request capture and ack (0..15)
// Ports   :
//   i_clk    in   1   clock, all logic on posedge
//   i_reset  in   1   synchronous active-high reset
//   i_req    in   1   request level; other inputs are stable while it is high
//   i_addr   in   16  byte address, bit 0 selects the byte lane
//   i_we     in   1   1=write, 0=read
//   i_bytew  in   1   1=byte access, 0=word access
//   i_d_in   in   16  write data; byte writes use [7:0]
//   o_d_out  out  16  read data, valid during ack and held until the next read ack
//   o_ack    out  1   one-cycle completion pulse
//   o_err    out  1   qualifies o_ack: access aborted, nothing written
// -----------------------------------------------------------------------------
module mem_responder
  import pdp11_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int WAIT_STATES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        i_we,
  input  logic        i_bytew,
  input  logic [15:0] i_d_in,
  output logic [15:0] o_d_out,
  output logic        o_ack,
  output logic        o_err
);

  localparam logic [3:0] WAIT_CNT_INIT = WAIT_STATES[3:0];

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_waitCnt;
  logic [15:0] r_addr;
  logic        r_we;
  logic        r_bytew;
  logic [15:0] r_dIn;
  logic [15:0] r_dOut;

  logic        w_nxm;
  logic        w_oddErr;
  logic        w_accessErr;
  logic [15:0] w_ramWord;
  logic [15:0] w_readData;
  logic [15:0] w_wrData;
  logic [1:0]  w_laneWe;

  // Any latched address bit at or above ADDR_WIDTH means non-existent
  // memory. A shift is used instead of a part-select, so that
  // ADDR_WIDTH=16 is still legal.
  assign w_nxm = (r_addr >> ADDR_WIDTH) != 16'h0000;

`ifdef ODD_ADDR_TRAP_EN
  assign w_oddErr = !r_bytew && r_addr[0];
`else
  assign w_oddErr = 1'b0;
`endif

  assign w_accessErr = w_nxm || w_oddErr;

  // A byte write places the byte on both lanes. The lane enables then pick
  // the lane that is actually written.
  assign w_wrData = r_bytew ? {r_dIn[7:0], r_dIn[7:0]} : r_dIn;

  assign w_readData = r_bytew ? {8'h00, (r_addr[0] == LANE_HI) ? w_ramWord[15:8] : w_ramWord[7:0]}
                              : w_ramWord;

  // The write commits at the edge that ends the ACK cycle. It is suppressed
  // if reset is asserted on that same edge.
  assign w_laneWe = (r_state == ST_ACK && r_we && !w_accessErr && !i_reset)
                    ? laneEnables(r_bytew, r_addr[0]) : 2'b00;

  mem_byte_array #(
    .WORD_AW (ADDR_WIDTH - 1)
  ) u_ram (
    .i_clk      (i_clk),
    .i_wordAddr (r_addr[ADDR_WIDTH-1:1]),
    .i_laneWe   (w_laneWe),
    .i_wrData   (w_wrData),
    .o_rdData   (w_ramWord)
  );

  // State register, request latch, wait counter and the held read data.
  // The request is latched on entry from IDLE, so later changes on the bus
  // inputs have no effect on the current transaction.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_waitCnt <= 4'd0;
      r_addr    <= 16'h0000;
      r_we      <= 1'b0;
      r_bytew   <= 1'b0;
      r_dIn     <= 16'h0000;
      r_dOut    <= 16'h0000;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_addr    <= i_addr;
            r_we      <= i_we;
            r_bytew   <= i_bytew;
            r_dIn     <= i_d_in;
            r_waitCnt <= WAIT_CNT_INIT;
          end
        end
        ST_WAIT: begin
          r_waitCnt <= r_waitCnt - 4'd1;
        end
        ST_ACK: begin
          if (!r_we && !w_accessErr) begin
            r_dOut <= w_readData;
          end
        end
        default: begin
          r_waitCnt <= 4'd0;
        end
      endcase
    end
  end

  // Next-state logic and the ack/err outputs.
  // With zero wait states the FSM goes from IDLE straight to ACK. Otherwise
  // WAIT counts down and hands over to ACK when the counter reaches 1.
  always_comb begin
    w_nextState = r_state;
    o_ack       = 1'b0;
    o_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          w_nextState = (WAIT_CNT_INIT == 4'd0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_waitCnt <= 4'd1) begin
          w_nextState = ST_ACK;
        end
      end
      ST_ACK: begin
        o_ack       = 1'b1;
        o_err       = w_accessErr;
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // During a successful read ack, the fresh data is shown directly.
  // At all other times the last read value is held.
  assign o_d_out = (r_state == ST_ACK && !r_we && !w_accessErr) ? w_readData : r_dOut;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Purpose : Directed testbench for mem_responder. Three responders share the
//           same bus inputs, with 2, 0 and 15 wait states. The 2-wait-state
//           instance carries the functional tests. The other two are used
//           for the handshake-timing test.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req;
  logic [15:0] addr;
  logic        we;
  logic        bytew;
  logic [15:0] dIn;

  logic [15:0] dOut,  dOut0,  dOut15;
  logic        ack,   ack0,   ack15;
  logic        err,   err0,   err15;

  int assertCount = 0;
  int failCount   = 0;

  int          lat;
  logic [15:0] rd;
  logic        e;
  logic [15:0] heldVal;

  mem_responder #(.ADDR_WIDTH(13), .WAIT_STATES(2)) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_addr(addr), .i_we(we),
    .i_bytew(bytew), .i_d_in(dIn), .o_d_out(dOut), .o_ack(ack), .o_err(err)
  );

  mem_responder #(.ADDR_WIDTH(13), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_addr(addr), .i_we(we),
    .i_bytew(bytew), .i_d_in(dIn), .o_d_out(dOut0), .o_ack(ack0), .o_err(err0)
  );

  mem_responder #(.ADDR_WIDTH(13), .WAIT_STATES(15)) dut15 (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_addr(addr), .i_we(we),
    .i_bytew(bytew), .i_d_in(dIn), .o_d_out(dOut15), .o_ack(ack15), .o_err(err15)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point. It counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Runs one transaction on the 2-wait-state responder. It returns the cycle
  // in which ack was seen (1 = the first cycle after the capture edge), plus
  // d_out and err as seen in that cycle. req is dropped in the ack cycle.
  task automatic applyStimulus(input string tag, input logic wrEn, input logic isByte,
                               input logic [15:0] a, input logic [15:0] d,
                               output int latency, output logic [15:0] rdData,
                               output logic errOut);
    logic got;
    @(negedge clk);
    addr  = a;
    we    = wrEn;
    bytew = isByte;
    dIn   = d;
    req   = 1'b1;
    @(posedge clk);
    latency = 0;
    got     = 1'b0;
    rdData  = 16'h0000;
    errOut  = 1'b0;
    while (!got && latency < 40) begin
      @(negedge clk);
      latency++;
      if (ack) begin
        got    = 1'b1;
        rdData = dOut;
        errOut = err;
        req    = 1'b0;
      end
    end
    req = 1'b0;
    checkOutput({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    req   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    addr  = 16'h0000;
    we    = 1'b0;
    bytew = 1'b0;
    dIn   = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ack",  {31'd0, ack}, 32'd0);
    checkOutput("reset_err",  {31'd0, err}, 32'd0);
    checkOutput("reset_dout", {16'd0, dOut}, 32'h0000);
    reset = 1'b0;

    // Test 1: word write and read back, checking ack latency.
    applyStimulus("t1_wr", 1'b1, 1'b0, 16'o1000, 16'o123456, lat, rd, e);
    checkOutput("t1_wr_lat", lat, 32'd3);
    checkOutput("t1_wr_err", {31'd0, e}, 32'd0);
    applyStimulus("t1_rd", 1'b0, 1'b0, 16'o1000, 16'h0000, lat, rd, e);
    checkOutput("t1_rd_lat",  lat, 32'd3);
    checkOutput("t1_rd_data", {16'd0, rd}, {16'd0, 16'o123456});
    checkOutput("t1_rd_err",  {31'd0, e}, 32'd0);
    @(negedge clk);
    checkOutput("t1_dout_held", {16'd0, dOut}, {16'd0, 16'o123456});

    // Test 2: a byte write into the high lane of an existing word.
    applyStimulus("t2_wr",  1'b1, 1'b0, 16'o1000, 16'h1234, lat, rd, e);
    applyStimulus("t2_bwr", 1'b1, 1'b1, 16'o1001, 16'h55AB, lat, rd, e);
    checkOutput("t2_bwr_err", {31'd0, e}, 32'd0);
    applyStimulus("t2_rd", 1'b0, 1'b0, 16'o1000, 16'h0000, lat, rd, e);
    checkOutput("t2_word", {16'd0, rd}, 32'h0000AB34);
    applyStimulus("t2_brhi", 1'b0, 1'b1, 16'o1001, 16'h0000, lat, rd, e);
    checkOutput("t2_byte_hi", {16'd0, rd}, 32'h000000AB);
    applyStimulus("t2_brlo", 1'b0, 1'b1, 16'o1000, 16'h0000, lat, rd, e);
    checkOutput("t2_byte_lo", {16'd0, rd}, 32'h00000034);

    // Test 3: accesses to non-existent memory. The NXM address would alias
    // to word 0 if its upper bits were dropped, so word 0 must stay intact.
    applyStimulus("t3_w0", 1'b1, 1'b0, 16'o0, 16'h0BAD, lat, rd, e);
    applyStimulus("t3_nrd", 1'b0, 1'b0, 16'o100000, 16'h0000, lat, rd, e);
    checkOutput("t3_nxm_rd_err", {31'd0, e}, 32'd1);
    checkOutput("t3_nxm_rd_lat", lat, 32'd3);
    checkOutput("t3_nxm_dout",   {16'd0, rd}, 32'h00000034);
    applyStimulus("t3_nwr", 1'b1, 1'b0, 16'o100000, 16'hDEAD, lat, rd, e);
    checkOutput("t3_nxm_wr_err", {31'd0, e}, 32'd1);
    applyStimulus("t3_rd0", 1'b0, 1'b0, 16'o0, 16'h0000, lat, rd, e);
    checkOutput("t3_word0", {16'd0, rd}, 32'h00000BAD);
    checkOutput("t3_rd0_err", {31'd0, e}, 32'd0);

    // Test 4: a word write to an odd address.
    applyStimulus("t4_clr", 1'b1, 1'b0, 16'o1002, 16'h0000, lat, rd, e);
    applyStimulus("t4_odd", 1'b1, 1'b0, 16'o1003, 16'hFFFF, lat, rd, e);
`ifdef ODD_ADDR_TRAP_EN
    checkOutput("t4_odd_err", {31'd0, e}, 32'd1);
    applyStimulus("t4_rd", 1'b0, 1'b0, 16'o1002, 16'h0000, lat, rd, e);
    checkOutput("t4_word", {16'd0, rd}, 32'h00000000);
`else
    checkOutput("t4_odd_err", {31'd0, e}, 32'd0);
    applyStimulus("t4_rd", 1'b0, 1'b0, 16'o1002, 16'h0000, lat, rd, e);
    checkOutput("t4_word", {16'd0, rd}, 32'h0000FFFF);
`endif

    // Test 5: reset arrives while a write is in its WAIT state.
    applyStimulus("t5_init", 1'b1, 1'b0, 16'o2000, 16'h1111, lat, rd, e);
    applyStimulus("t5_rd1",  1'b0, 1'b0, 16'o2000, 16'h0000, lat, rd, e);
    checkOutput("t5_pre_dout", {16'd0, rd}, 32'h00001111);
    @(negedge clk);
    addr  = 16'o2000;
    we    = 1'b1;
    bytew = 1'b0;
    dIn   = 16'h5555;
    req   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5_no_ack_wait", {31'd0, ack}, 32'd0);
    reset = 1'b1;
    req   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5_rst_ack",  {31'd0, ack}, 32'd0);
    checkOutput("t5_rst_err",  {31'd0, err}, 32'd0);
    checkOutput("t5_rst_dout", {16'd0, dOut}, 32'h00000000);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t5_no_late_ack", {31'd0, ack}, 32'd0);
    end
    applyStimulus("t5_rd2", 1'b0, 1'b0, 16'o2000, 16'h0000, lat, rd, e);
    checkOutput("t5_kept", {16'd0, rd}, 32'h00001111);

    // Test 6: req is held high. Each IDLE visit starts a new transaction,
    // so acks repeat every WAIT_STATES+2 cycles.
    pulseReset();
    addr  = 16'o1000;
    we    = 1'b0;
    bytew = 1'b0;
    dIn   = 16'h0000;
    req   = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t6_ws0_c%0d", i),  {31'd0, ack0},  {31'd0, (i % 2) == 1});
      checkOutput($sformatf("t6_ws2_c%0d", i),  {31'd0, ack},   {31'd0, (i % 4) == 3});
      checkOutput($sformatf("t6_ws15_c%0d", i), {31'd0, ack15}, {31'd0, i == 16});
      if (i == 16) begin
        checkOutput("t6_ws15_err", {31'd0, err15}, 32'd0);
      end
    end
    req = 1'b0;
    heldVal = dOut0;
    @(negedge clk);
    checkOutput("t6_ws0_err_idle", {31'd0, err0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
